// File: rtl/register_file.sv
// rtl/register_file.sv - 2**ADDR_WIDTH x DATA_WIDTH register file, one sync write port, one async read port
// Optional build macro REG_FILE_BYPASS_EN: forward w_data to r_data when writing the word being read.
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_address,
    input  logic [ADDR_WIDTH-1:0] r_address,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_rd;

    // Storage: asynchronous clear of every word, otherwise one word written per enabled edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[w_address] <= w_data;
        end
    end

    assign w_mem_rd = r_mem[r_address];

`ifdef REG_FILE_BYPASS_EN
    logic w_fwd;

    // Write-through: a word being written this cycle is visible to the reader before the edge
    always_comb begin
        w_fwd  = we && reset_n && (r_address == w_address);
        r_data = w_fwd ? w_data : w_mem_rd;
    end
`else
    // Plain read: the stored word only, new data appears after the write edge
    always_comb begin
        r_data = w_mem_rd;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized and directed checks of register_file against an array model
`timescale 1ns/1ps
module tb_register_file;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] w_address = '0;
    logic [2:0] r_address = '0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;

    logic [7:0] model [8];
    int total = 0;
    int bad   = 0;

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we),
        .w_address (w_address),
        .r_address (r_address),
        .w_data    (w_data),
        .r_data    (r_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Value a reader should see right now given the current inputs and stored contents
    function automatic logic [7:0] exp_read();
`ifdef REG_FILE_BYPASS_EN
        if (we && reset_n && (r_address == w_address)) return w_data;
`endif
        return model[r_address];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    endtask

    // One clock: inputs are applied after negedge, model follows the rising edge
    task automatic cycle(input logic e, input logic [2:0] wa, input logic [7:0] wd);
        @(negedge clk);
        we = e; w_address = wa; w_data = wd;
        @(posedge clk);
        if (e && reset_n) model[wa] = wd;
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 8; a++) begin
            r_address = a[2:0];
            #1;
            check_eq(tag, r_data, exp_read());
        end
    endtask

    initial begin
        clear_model();
        // Reset asserted from time 0, writes attempted during it must be ignored
        #2;
        sweep("reset_initial");
        we = 1'b1; w_address = 3'd4; w_data = 8'hCC;
        @(posedge clk); #1;
        we = 1'b0;
        r_address = 3'd4; #1;
        check_eq("reset_write_ignored", r_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        sweep("reset_released");

        // Fill and readback
        for (int i = 0; i < 8; i++) cycle(1'b1, i[2:0], 8'(i * 10));
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_address = i[2:0]; #1;
            check_eq("fill_readback", r_data, 8'(i * 10));
        end

        // we=0 hold
        for (int k = 0; k < 4; k++) cycle(1'b0, 3'd3, 8'hFF);
        r_address = 3'd3; #1;
        check_eq("hold_we0", r_data, 8'd30);

        // Overwrite
        cycle(1'b1, 3'd5, 8'hA5);
        cycle(1'b1, 3'd5, 8'h5A);
        we = 1'b0;
        r_address = 3'd5; #1; check_eq("overwrite_5", r_data, 8'h5A);
        r_address = 3'd4; #1; check_eq("overwrite_4", r_data, 8'd40);
        r_address = 3'd6; #1; check_eq("overwrite_6", r_data, 8'd60);

        // Same-address read/write in one cycle
        @(negedge clk);
        r_address = 3'd2; w_address = 3'd2; w_data = 8'h77; we = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check_eq("same_addr_before", r_data, 8'h77);
`else
        check_eq("same_addr_before", r_data, 8'd20);
`endif
        @(posedge clk); model[2] = 8'h77; #1;
        check_eq("same_addr_after", r_data, 8'h77);
        we = 1'b0; #1;
        check_eq("same_addr_after_we0", r_data, 8'h77);

        // Asynchronous reset pulse between edges
        @(negedge clk);
        #2 reset_n = 1'b0;
        clear_model();
        #1 reset_n = 1'b1;
        sweep("reset_pulse");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we        = 1'($urandom_range(0, 1));
            w_address = 3'($urandom_range(0, 7));
            r_address = ($urandom_range(0, 3) == 0) ? w_address : 3'($urandom_range(0, 7));
            w_data    = 8'($urandom);
            #1;
            check_eq("rand_before", r_data, exp_read());
            @(posedge clk);
            if (we) model[w_address] = w_data;
            #1;
            check_eq("rand_after", r_data, exp_read());
        end
        we = 1'b0;
        sweep("rand_final");

        // Reset coincident with a write to the last word, after a fresh fill
        for (int i = 0; i < 8; i++) cycle(1'b1, i[2:0], 8'(i * 10 + 1));
        @(negedge clk);
        we = 1'b1; w_address = 3'd7; w_data = 8'hEE;
        @(posedge clk);
        reset_n = 1'b0;
        clear_model();
        #1;
        we = 1'b0;
        sweep("reset_midwrite_low");
        @(negedge clk);
        reset_n = 1'b1;
        sweep("reset_midwrite_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
